pipeline_hazard_controller: RTL

Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB). It combines four event sources into per-stage-register write enables and flushes:
- load-use hazards
- EX-resolved taken branches
- data-memory wait states
- halt/drain requests

It also runs a memory-timeout watchdog and a stall-cycle performance counter. It sits beside the pipeline registers and drives their enable/flush pins.

---
 rtl/pipeline_hazard_controller.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: turns load-use, branch, data-memory wait
// and halt events into pipeline-register enables/flushes, plus a memory watchdog and stall counter.
module pipeline_hazard_controller #(
   parameter int MEM_TIMEOUT  = 64,
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       if_id_rs1,
   input  logic [4:0]       if_id_rs2,
   input  logic             if_id_use_rs1,
   input  logic             if_id_use_rs2,
   input  logic             id_ex_memread,
   input  logic [4:0]       id_ex_rd,
   input  logic             ex_branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   input  logic             halt_req,
   input  logic             resume,
   output logic             pc_write,
   output logic             pc_redirect,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_write,
   output logic             id_ex_flush,
   output logic             ex_mem_write,
   output logic             mem_wb_bubble,
   output logic             halted,
   output logic             mem_timeout_err,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int TW = $clog2(MEM_TIMEOUT + 1);
   localparam int DW = $clog2(DRAIN_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LIM = TW'(MEM_TIMEOUT);
   localparam logic [DW-1:0] DRN_LIM = DW'(DRAIN_CYCLES);

   typedef enum logic [2:0] {
      S_RUN,
      S_MEM_WAIT,
      S_DRAIN,
      S_HALTED,
      S_ERROR
   } state_t;

   state_t           state_q, state_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic [DW-1:0]    drain_q, drain_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic lu, ms;

   assign lu = id_ex_memread && (id_ex_rd != 5'd0) &&
               ((if_id_use_rs1 && (if_id_rs1 == id_ex_rd)) ||
                (if_id_use_rs2 && (if_id_rs2 == id_ex_rd)));
   assign ms = dmem_req && !dmem_ready;

   assign stall_cycles = stall_q;

   // NOTE: every output and next-state signal gets a default first so no path leaves a latch.
   always_comb begin
      pc_write        = 1'b1;
      pc_redirect     = 1'b0;
      if_id_write     = 1'b1;
      if_id_flush     = 1'b0;
      id_ex_write     = 1'b1;
      id_ex_flush     = 1'b0;
      ex_mem_write    = 1'b1;
      mem_wb_bubble   = 1'b0;
      halted          = 1'b0;
      mem_timeout_err = 1'b0;
      state_d         = state_q;
      tmo_d           = tmo_q;
      drain_d         = drain_q;
      stall_d         = stall_q;

      if (rst) begin
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         id_ex_write   = 1'b0;
         ex_mem_write  = 1'b0;
         if_id_flush   = 1'b1;
         id_ex_flush   = 1'b1;
         mem_wb_bubble = 1'b1;
      end else begin
         case (state_q)
            S_RUN, S_MEM_WAIT: begin
               if (ms) begin
                  // Freeze everything up to EX/MEM; a pending branch waits until memory completes.
                  pc_write      = 1'b0;
                  if_id_write   = 1'b0;
                  id_ex_write   = 1'b0;
                  ex_mem_write  = 1'b0;
                  mem_wb_bubble = 1'b1;
                  if (state_q == S_RUN) begin
                     state_d = S_MEM_WAIT;
                     tmo_d   = TW'(1);
                  end else if ((tmo_q + TW'(1)) >= TMO_LIM) begin
                     state_d = S_ERROR;
                  end else begin
                     tmo_d = tmo_q + TW'(1);
                  end
               end else begin
                  state_d = S_RUN;
                  if (ex_branch_taken) begin
                     pc_redirect = 1'b1;
                     if_id_flush = 1'b1;
                     id_ex_flush = 1'b1;
                  end else if (lu) begin
                     pc_write    = 1'b0;
                     if_id_write = 1'b0;
                     id_ex_flush = 1'b1;
                  end else if (halt_req) begin
                     pc_write    = 1'b0;
                     if_id_flush = 1'b1;
                     state_d     = S_DRAIN;
                     drain_d     = DW'(1);
                  end
               end
            end

            S_DRAIN: begin
               pc_write    = 1'b0;
               if_id_flush = 1'b1;
               if (ms) begin
                  if_id_write   = 1'b0;
                  id_ex_write   = 1'b0;
                  ex_mem_write  = 1'b0;
                  mem_wb_bubble = 1'b1;
               end else if (drain_q == DRN_LIM) begin
                  state_d = S_HALTED;
               end else begin
                  drain_d = drain_q + DW'(1);
               end
            end

            S_HALTED: begin
               halted        = 1'b1;
               pc_write      = 1'b0;
               if_id_write   = 1'b0;
               id_ex_write   = 1'b0;
               ex_mem_write  = 1'b0;
               mem_wb_bubble = 1'b1;
               if (resume) state_d = S_RUN;
            end

            S_ERROR: begin
               mem_timeout_err = 1'b1;
               pc_write        = 1'b0;
               if_id_write     = 1'b0;
               id_ex_write     = 1'b0;
               ex_mem_write    = 1'b0;
               mem_wb_bubble   = 1'b1;
            end

            default: state_d = S_RUN;
         endcase

         if (!pc_write && (state_q inside {S_RUN, S_MEM_WAIT, S_DRAIN}) && (stall_q != '1))
            stall_d = stall_q + CNT_W'(1);
      end
   end

   // NOTE: reset is synchronous, so it lives inside the clocked block and is only seen on an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RUN;
         tmo_q   <= '0;
         drain_q <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         drain_q <= drain_d;
         stall_q <= stall_d;
      end
   end

endmodule
